mfetch: RTL

- Main-core instruction fetch stage; sits directly upstream of the decode stage.
- Holds the program counter and issues one 64-bit bundle (upper and lower instruction) read per cycle to the pipelined instruction memory.
- Buffers returned bundles in a small FIFO so decode interlock never loses data.
- Presents {pc, inst} to decode and redirects on decode's branch_flag/branch_pc, squashing stale fetches.

---
 rtl/inst_package.sv | 16 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/mfetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/inst_package.sv
// rtl/inst_package.sv - shared fetch/decode constants and the fetch bundle entry type
package inst_package;

    localparam logic [5:0]  NOP_OPCODE   = 6'h3c;
    localparam logic [63:0] NOP_BUNDLE   = {NOP_OPCODE, 26'b0, NOP_OPCODE, 26'b0};
    localparam int          DEF_IMEM_LAT = 2;
    localparam int          DEF_DEPTH    = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, inst: NOP_BUNDLE};

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - bundle FIFO with registered head; flush beats push, empty head reads as bubble
module fetch_fifo
    import inst_package::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     push_data_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     head_q, head_d;
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_push = push_i && !flush_i;
        do_pop  = pop_i && !flush_i && (count_q != '0);
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        head_d  = head_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            head_d  = EMPTY_ENTRY;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            // The next head may be the entry being written this cycle, so bypass it.
            if (count_d == '0)
                head_d = EMPTY_ENTRY;
            else if (do_push && (rd_d == wr_q))
                head_d = push_data_i;
            else
                head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            head_q  <= EMPTY_ENTRY;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/mfetch.sv
// rtl/mfetch.sv - main-core fetch stage: PC, credit-gated imem issue, in-flight tags, bundle FIFO
// Optional FETCH_PERF_EN adds saturating bubble/redirect counters.
module mfetch
    import inst_package::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IMEM_LAT = DEF_IMEM_LAT,
    parameter int          DEPTH    = DEF_DEPTH,
    parameter int          ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              interlock,
    input  logic              branch_flag,
    input  logic [31:0]       branch_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [63:0]       imem_dout,
    output logic [31:0]       pc,
    output logic [63:0]       inst
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_redirect_cnt
`endif
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int USED_W = CNT_W + 1;

    if (IMEM_LAT < 1 || IMEM_LAT > 4) begin : g_lat_check
        $error("mfetch: IMEM_LAT must be in 1..4");
    end
    if (DEPTH < IMEM_LAT + 1) begin : g_depth_check
        $error("mfetch: DEPTH must be at least IMEM_LAT+1");
    end

    logic [31:0]         fpc_q, fpc_d;
    logic [IMEM_LAT-1:0] vld_q, vld_d;
    logic [31:0]         tag_q [IMEM_LAT];
    logic [31:0]         tag_d [IMEM_LAT];
    logic [CNT_W-1:0]    fifo_count;
    logic [USED_W-1:0]   used;
    logic [31:0]         req_pc;
    logic                issue;
    fetch_entry_t        head;
    fetch_entry_t        push_entry;

    always_comb begin
        used = USED_W'(fifo_count);
        for (int i = 0; i < IMEM_LAT; i++) used = used + USED_W'(vld_q[i]);
    end

    // A redirect always issues: the flush it causes frees every credit.
    assign issue  = rstn && (branch_flag || (used < USED_W'(DEPTH)));
    assign req_pc = branch_flag ? branch_pc : fpc_q;

    always_comb begin
        fpc_d    = issue ? req_pc + 32'd1 : fpc_q;
        vld_d[0] = issue;
        tag_d[0] = req_pc;
        for (int i = 1; i < IMEM_LAT; i++) begin
            vld_d[i] = branch_flag ? 1'b0 : vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fpc_q <= RESET_PC;
            vld_q <= '0;
        end else begin
            fpc_q <= fpc_d;
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < IMEM_LAT; i++) tag_q[i] <= tag_d[i];
    end

    assign push_entry = '{pc: tag_q[IMEM_LAT-1], inst: imem_dout};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (vld_q[IMEM_LAT-1] && !branch_flag),
        .pop_i       (!interlock && !branch_flag),
        .flush_i     (branch_flag),
        .push_data_i (push_entry),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign imem_en   = issue;
    assign imem_addr = req_pc[ADDR_W-1:0];
    assign pc        = head.pc;
    assign inst      = head.inst;

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt_q, redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bubble_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (!interlock && !branch_flag && fifo_count == '0 && bubble_cnt_q != '1)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (branch_flag && redirect_cnt_q != '1)
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign perf_bubble_cnt   = bubble_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule
